// File: rtl/alu_scheduler.sv
// alu_scheduler
//   Shares one ALU datapath between two requesters (port 0: core execute
//   stage, port 1: secondary address/loop engine). Requests are arbitrated
//   round-robin and operands are latched on grant. Single-cycle ops go
//   through the external combinational ALU; DIV (opcode 101) runs on an
//   internal restoring divider, one quotient bit per cycle.
//
// Ports
//   Clk, Reset_n          clock, asynchronous active-low reset
//   Req0/Op0/A0/B0        requester 0 request, opcode, operands
//   Req1/Op1/A1/B1        requester 1 request, opcode, operands
//   Gnt0, Gnt1            one-cycle acceptance pulses (IDLE only)
//   AluA, AluB, AluOp     operands/opcode driven to the external ALU
//   AluOut1               external ALU result
//   Busy                  op accepted and not yet completed
//   Done, DoneId          one-cycle result-valid pulse and owning requester
//   Result1, Result2      result / quotient, and remainder for DIV (else 0)
//   ResultZero            Result1 == 0
//   DivByZero             DIV with B == 0 (valid with Done)
module alu_scheduler #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned DIV_STEPS = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Req0,
  input  logic [2:0]       Op0,
  input  logic [WIDTH-1:0] A0,
  input  logic [WIDTH-1:0] B0,
  input  logic             Req1,
  input  logic [2:0]       Op1,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] B1,
  output logic             Gnt0,
  output logic             Gnt1,
  output logic [WIDTH-1:0] AluA,
  output logic [WIDTH-1:0] AluB,
  output logic [2:0]       AluOp,
  input  logic [WIDTH-1:0] AluOut1,
  output logic             Busy,
  output logic             Done,
  output logic             DoneId,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             ResultZero,
  output logic             DivByZero
);

  localparam logic [2:0]  OP_NOP0 = 3'b000;
  localparam logic [2:0]  OP_DIV  = 3'b101;
  localparam logic [2:0]  OP_NOP7 = 3'b111;
  localparam int unsigned CW      = $clog2(DIV_STEPS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DIV  = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t           state;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             owner;
  logic             last_gnt;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] r_r;
  logic [CW-1:0]    cnt;

  logic             win;
  logic             grant;
  logic [2:0]       sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             sel_quiet;
  logic [WIDTH:0]   r_sh;
  logic [WIDTH-1:0] r_nx;
  logic [WIDTH-1:0] q_nx;
  logic [WIDTH-1:0] exec_res;

  // Arbitration: a sole requester wins; on contention the one that did not
  // win last time goes. Grant is masked while reset is asserted so no
  // acceptance pulse can escape during reset.
  always_comb begin
    win       = (Req0 && Req1) ? ~last_gnt : Req1;
    grant     = (state == IDLE) && (Req0 || Req1) && Reset_n;
    Gnt0      = grant && !win;
    Gnt1      = grant && win;
    sel_op    = win ? Op1 : Op0;
    sel_a     = win ? A1  : A0;
    sel_b     = win ? B1  : B0;
    sel_quiet = (sel_op == OP_DIV) || (sel_op == OP_NOP0) || (sel_op == OP_NOP7);
    Busy      = (state != IDLE);
    Done      = (state == RESP);
  end

  // One restoring-division step. The shifted partial remainder is kept one
  // bit wider so divisors above 2^(WIDTH-1) still compare correctly; after
  // the conditional subtract it always fits back in WIDTH bits.
  always_comb begin
    r_sh = {r_r, q_r[WIDTH-1]};
    q_nx = {q_r[WIDTH-2:0], 1'b0};
    r_nx = r_sh[WIDTH-1:0];
    if (r_sh >= {1'b0, b_q}) begin
      r_nx    = WIDTH'(r_sh - {1'b0, b_q});
      q_nx[0] = 1'b1;
    end
    exec_res = ((op_q == OP_NOP0) || (op_q == OP_NOP7)) ? '0 : AluOut1;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      owner      <= 1'b0;
      last_gnt   <= 1'b1;
      q_r        <= '0;
      r_r        <= '0;
      cnt        <= '0;
      AluA       <= '0;
      AluB       <= '0;
      AluOp      <= '0;
      DoneId     <= 1'b0;
      Result1    <= '0;
      Result2    <= '0;
      ResultZero <= 1'b0;
      DivByZero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            op_q     <= sel_op;
            a_q      <= sel_a;
            b_q      <= sel_b;
            owner    <= win;
            last_gnt <= win;
            AluA     <= sel_a;
            AluB     <= sel_b;
            AluOp    <= sel_quiet ? 3'b000 : sel_op;
            q_r      <= sel_a;
            r_r      <= '0;
            cnt      <= '0;
            state    <= (sel_op == OP_DIV) ? DIV : EXEC;
          end
        end
        EXEC: begin
          Result1    <= exec_res;
          Result2    <= '0;
          ResultZero <= (exec_res == '0);
          DivByZero  <= 1'b0;
          DoneId     <= owner;
          state      <= RESP;
        end
        DIV: begin
          if (b_q == '0) begin
            Result1    <= '1;
            Result2    <= a_q;
            ResultZero <= 1'b0;
            DivByZero  <= 1'b1;
            DoneId     <= owner;
            state      <= RESP;
          end else begin
            q_r <= q_nx;
            r_r <= r_nx;
            cnt <= cnt + 1'b1;
            if (cnt == CW'(DIV_STEPS - 1)) begin
              Result1    <= q_nx;
              Result2    <= r_nx;
              ResultZero <= (q_nx == '0);
              DivByZero  <= 1'b0;
              DoneId     <= owner;
              state      <= RESP;
            end
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_scheduler.sv
module tb_alu_scheduler;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ASGN = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_MULT = 3'b100;
  localparam logic [2:0] OP_DIV  = 3'b101;
  localparam logic [2:0] OP_SHL  = 3'b110;
  localparam logic [2:0] OP_NOP7 = 3'b111;

  logic        Clk;
  logic        Reset_n;
  logic        Req0, Req1;
  logic [2:0]  Op0, Op1;
  logic [15:0] A0, B0, A1, B1;
  logic        Gnt0, Gnt1;
  logic [15:0] AluA, AluB;
  logic [2:0]  AluOp;
  logic [15:0] AluOut1;
  logic        Busy, Done, DoneId;
  logic [15:0] Result1, Result2;
  logic        ResultZero, DivByZero;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  alu_scheduler #(.WIDTH(16), .DIV_STEPS(16)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .Req0(Req0), .Op0(Op0), .A0(A0), .B0(B0),
    .Req1(Req1), .Op1(Op1), .A1(A1), .B1(B1),
    .Gnt0(Gnt0), .Gnt1(Gnt1),
    .AluA(AluA), .AluB(AluB), .AluOp(AluOp), .AluOut1(AluOut1),
    .Busy(Busy), .Done(Done), .DoneId(DoneId),
    .Result1(Result1), .Result2(Result2),
    .ResultZero(ResultZero), .DivByZero(DivByZero)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // External combinational ALU; unknown opcodes return a marker value so a
  // NOP that wrongly forwards AluOut1 is visible.
  always_comb begin
    case (AluOp)
      OP_ASGN: AluOut1 = AluA;
      OP_ADD:  AluOut1 = AluA + AluB;
      OP_SUB:  AluOut1 = AluA - AluB;
      OP_MULT: AluOut1 = 16'(AluA * AluB);
      OP_SHL:  AluOut1 = (AluB >= 16'd16) ? 16'h0000 : (AluA << AluB[3:0]);
      default: AluOut1 = 16'hDEAD;
    endcase
  end

  task automatic nxt();
    @(negedge Clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op from requester id, drop the request the cycle after Gnt,
  // then wait (bounded) for Done and check latency and results.
  task automatic run_op(input string tag, input logic id, input logic [2:0] op,
                        input logic [15:0] a, input logic [15:0] b, input int lat,
                        input logic [2:0] exp_aluop, input logic [15:0] e1,
                        input logic [15:0] e2, input logic ez, input logic edbz);
    int n;
    bit seen;
    nxt();
    if (id) begin Req1 = 1'b1; Op1 = op; A1 = a; B1 = b; end
    else    begin Req0 = 1'b1; Op0 = op; A0 = a; B0 = b; end
    #1;
    chk({tag, "_gnt"}, {30'd0, Gnt1, Gnt0}, id ? 32'd2 : 32'd1);
    chk({tag, "_busy_at_gnt"}, {31'd0, Busy}, 32'd0);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      nxt();
      n++;
      if (n == 1) begin
        Req0 = 1'b0;
        Req1 = 1'b0;
        #1;
        chk({tag, "_aluop"}, {29'd0, AluOp}, {29'd0, exp_aluop});
        chk({tag, "_busy"}, {31'd0, Busy}, 32'd1);
      end else begin
        #1;
      end
      if (Done) seen = 1'b1;
    end
    chk({tag, "_latency"}, n, lat);
    chk({tag, "_doneid"}, {31'd0, DoneId}, {31'd0, id});
    chk({tag, "_result1"}, {16'd0, Result1}, {16'd0, e1});
    chk({tag, "_result2"}, {16'd0, Result2}, {16'd0, e2});
    chk({tag, "_zero"}, {31'd0, ResultZero}, {31'd0, ez});
    chk({tag, "_dbz"}, {31'd0, DivByZero}, {31'd0, edbz});
    nxt();
    #1;
    chk({tag, "_idle"}, {30'd0, Done, Busy}, 32'd0);
  endtask

  initial begin
    Reset_n = 1'b0;
    Req0 = 1'b0; Op0 = '0; A0 = '0; B0 = '0;
    Req1 = 1'b0; Op1 = '0; A1 = '0; B1 = '0;

    // Reset state
    nxt(); nxt(); #1;
    chk("rst_ctl", {26'd0, Gnt0, Gnt1, Done, Busy, DivByZero, ResultZero}, 32'd0);
    chk("rst_doneid", {31'd0, DoneId}, 32'd0);
    chk("rst_results", {Result1, Result2}, 32'd0);
    chk("rst_alu", {13'd0, AluOp, AluA[7:0], AluB[7:0]}, 32'd0);
    chk("rst_alu_hi", {AluA, AluB}, 32'd0);
    nxt();
    Reset_n = 1'b1;

    run_op("add",    1'b0, OP_ADD,  16'h0003, 16'h0004, 2,  OP_ADD,  16'h0007, 16'h0000, 1'b0, 1'b0);
    run_op("div7",   1'b0, OP_DIV,  16'd100,  16'd7,    17, OP_NOP,  16'h000E, 16'h0002, 1'b0, 1'b0);
    run_op("divff",  1'b0, OP_DIV,  16'hFFFF, 16'h0001, 17, OP_NOP,  16'hFFFF, 16'h0000, 1'b0, 1'b0);
    run_op("div0",   1'b1, OP_DIV,  16'h0005, 16'h0000, 2,  OP_NOP,  16'hFFFF, 16'h0005, 1'b0, 1'b1);

    // Both requesters held continuously: grants must alternate 0,1,0,1.
    nxt();
    Req0 = 1'b1; Op0 = OP_SUB; A0 = 16'd5; B0 = 16'd5;
    Req1 = 1'b1; Op1 = OP_SUB; A1 = 16'd5; B1 = 16'd5;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rr%0d_gnt", k), {30'd0, Gnt1, Gnt0}, (k % 2 == 1) ? 32'd2 : 32'd1);
      nxt(); #1;
      chk($sformatf("rr%0d_nognt_busy", k), {30'd0, Gnt1, Gnt0}, 32'd0);
      nxt(); #1;
      chk($sformatf("rr%0d_done", k), {31'd0, Done}, 32'd1);
      chk($sformatf("rr%0d_doneid", k), {31'd0, DoneId}, (k % 2 == 1) ? 32'd1 : 32'd0);
      chk($sformatf("rr%0d_res", k), {15'd0, ResultZero, Result1}, {15'd0, 1'b1, 16'h0000});
      nxt();
      if (k == 3) begin
        Req0 = 1'b0;
        Req1 = 1'b0;
      end
      #1;
    end
    chk("rr_quiet", {29'd0, Gnt1, Gnt0, Busy}, 32'd0);

    run_op("mult",   1'b0, OP_MULT, 16'h1234, 16'h0100, 2,  OP_MULT, 16'h3400, 16'h0000, 1'b0, 1'b0);
    run_op("subwrap",1'b1, OP_SUB,  16'h0000, 16'h0001, 2,  OP_SUB,  16'hFFFF, 16'h0000, 1'b0, 1'b0);
    run_op("nop7",   1'b0, OP_NOP7, 16'h1111, 16'h2222, 2,  OP_NOP,  16'h0000, 16'h0000, 1'b1, 1'b0);

    // Reset in the middle of a DIV: everything clears at once, no Done.
    nxt();
    Req0 = 1'b1; Op0 = OP_DIV; A0 = 16'h1234; B0 = 16'h0003;
    #1;
    chk("rdiv_gnt", {30'd0, Gnt1, Gnt0}, 32'd1);
    nxt();
    Req0 = 1'b0;
    for (int i = 0; i < 7; i++) nxt();
    Reset_n = 1'b0;
    Req1 = 1'b1; Op1 = OP_SUB; A1 = 16'd9; B1 = 16'd4;
    #1;
    chk("rdiv_ctl", {26'd0, Gnt0, Gnt1, Done, Busy, DivByZero, ResultZero}, 32'd0);
    chk("rdiv_results", {Result1, Result2}, 32'd0);
    chk("rdiv_alu", {AluA, AluB}, 32'd0);
    chk("rdiv_aluop", {29'd0, AluOp}, 32'd0);
    nxt(); #1;
    chk("rdiv_hold", {30'd0, Done, Gnt1}, 32'd0);
    nxt();
    Reset_n = 1'b1;
    #1;
    chk("rdiv_first_gnt", {30'd0, Gnt1, Gnt0}, 32'd2);
    nxt();
    Req1 = 1'b0;
    #1;
    chk("rdiv_no_stale_done", {31'd0, Done}, 32'd0);
    nxt(); #1;
    chk("rdiv_sub_done", {31'd0, Done}, 32'd1);
    chk("rdiv_sub_res", {15'd0, DoneId, Result1}, {15'd0, 1'b1, 16'h0005});
    nxt();

    // Last winner is requester 0; a reset must restore priority to port 0.
    run_op("asgn",   1'b0, OP_ASGN, 16'hABCD, 16'h0000, 2,  OP_ASGN, 16'hABCD, 16'h0000, 1'b0, 1'b0);
    nxt();
    Reset_n = 1'b0;
    Req0 = 1'b1; Op0 = OP_ADD; A0 = 16'h0010; B0 = 16'h0020;
    Req1 = 1'b1; Op1 = OP_ADD; A1 = 16'h0001; B1 = 16'h0001;
    nxt();
    Reset_n = 1'b1;
    #1;
    chk("rst2_gnt", {30'd0, Gnt1, Gnt0}, 32'd1);
    nxt();
    Req0 = 1'b0;
    Req1 = 1'b0;
    nxt(); #1;
    chk("rst2_done", {14'd0, Done, DoneId, Result1}, {14'd0, 1'b1, 1'b0, 16'h0030});
    nxt();

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
